pe_row_requant: RTL and testbench
=================================

Name: pe_row_requant

Overview:
- Downstream of the PE systolic array: captures one row of N_COLS 32-bit signed MAC results in a single cycle.
- Requantizes each result to int8 as sat8(round((acc*scale) >>> shift) + zero_point).
- Streams the results out one per beat over a valid/ready interface toward the activation/writeback stage.
- Frees the PE row for its next accumulation as soon as the capture completes.

Parameters:
- N_COLS, 8, number of PE accumulators captured per row.
- ACC_W, 32, accumulator width (signed).
- SCALE_W, 16, requant multiplier width (signed).
- OUT_W, 8, output width (signed).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_arst  in  1  reset, asynchronous, active-high.
- i_capture  in  1  capture pulse; sampled in IDLE only.
- i_acc  in  N_COLS*ACC_W  packed accumulators; column k at bits [k*ACC_W +: ACC_W].
- i_scale  in  SCALE_W  signed multiplier; latched on capture.
- i_shift  in  6  unsigned right shift; latched on capture.
- i_zero_point  in  OUT_W  signed output offset; latched on capture.
- o_busy  out  1  high while a row is held or draining.
- o_valid  out  1  output beat valid.
- i_ready  in  1  consumer accepts the beat.
- o_data  out  OUT_W  signed requantized value.
- o_index  out  $clog2(N_COLS)  column index of the current beat.
- o_last  out  1  high on the beat for column N_COLS-1.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; row buffer, config registers and pipeline registers cleared. Reset asserted mid-drain aborts the row. No beat is emitted after reset is released until a new capture.
- FSM states and transitions:
  - IDLE: when i_capture=1, latch i_acc, i_scale, i_shift and i_zero_point; set issue index to 0; go to DRAIN. i_capture in any other state is ignored, with no queueing.
  - DRAIN: issue one column per advancing cycle into the pipeline. After column N_COLS-1 is issued, go to FLUSH.
  - FLUSH: wait until the o_last beat completes the handshake (o_valid & i_ready), then go to IDLE.
- o_busy = (state != IDLE), registered. It rises the cycle after capture and falls the cycle after the last handshake. i_capture can be honoured in that same cycle.
- Pipeline, 3 register stages:
  - S1 product: acc*scale, 48-bit signed.
  - S2 round/shift: shift is clamped to 47 if larger. If shift > 0, compute (p + (1<<(shift-1))) >>> shift; ties therefore round toward +inf. If shift = 0, pass p unchanged.
  - S3 output register: add sign-extended zero_point in 49 bits, saturate to [-128, 127], drive o_data, o_index, o_last, o_valid.
- Latency: capture at edge T gives first o_valid=1 after edge T+3 when i_ready is held high. Throughput is 1 beat/cycle.
- Handshake and backpressure:
  - Stall condition: o_valid & !i_ready freezes all stages and the issue index. o_data, o_index and o_last stay stable; no beat is lost or duplicated.
  - o_valid never drops without a handshake.
  - i_ready may be high with o_valid=0 (no effect).
- Beats leave in order, indices 0..N_COLS-1. Exactly N_COLS beats per capture.
- Config and i_acc may change freely after the capture cycle without affecting the row in flight.

Test Plan:
- Rounding, i_scale=1, i_shift=3, i_zero_point=0, i_ready=1:
  - acc 1000 -> 125.
  - acc -1000 -> -125.
  - acc 12 -> 2.
  - acc -12 -> -1.
  - First o_valid 3 cycles after capture; o_index 0..7 in order; o_last only on index 7.
- Saturation and zero point, shift=0:
  - acc 100000 -> 127.
  - acc -100000 -> -128.
  - acc 20 with zp=-5 -> 15.
  - acc 125 with zp=10 -> 127.
  - Scale path: scale=-3, acc 40, shift=1 -> -60.
- Backpressure: drop i_ready for 5 cycles after beat 2 and for 1 cycle before the last beat -> o_data/o_index held stable throughout; all 8 beats delivered exactly once and in order.
- Capture while busy: pulse i_capture with different i_acc during DRAIN -> ignored; the original row is emitted. A capture in the cycle after the last handshake (o_busy=0) is accepted.
- Reset mid-drain: assert i_arst after beat 3 -> all outputs 0 immediately; no further beats. A new capture afterwards yields a complete 8-beat row.
- Back-to-back rows with i_ready=1 and capture on the first idle cycle -> 16 beats with a 1-cycle o_busy gap; values from the second row use the second row's latched config.

Source files
------------

// File: rtl/pe_row_requant.sv
// pe_row_requant: captures one row of signed PE accumulators in a single cycle,
// requantizes each column to a signed OUT_W value as
//   sat(round((acc * scale) >>> shift) + zero_point)
// and streams the results out one beat per cycle over valid/ready.
//
// Ports:
//   i_clk, i_arst        clock, asynchronous active-high reset
//   i_capture            capture pulse, honoured only while idle
//   i_acc                packed accumulators, column k at [k*ACC_W +: ACC_W]
//   i_scale, i_shift,
//   i_zero_point         requant config, latched together with i_acc
//   o_busy               a row is held or still draining
//   o_valid, i_ready     output handshake
//   o_data, o_index,
//   o_last               requantized value, its column, last-column flag
module pe_row_requant #(
  parameter int unsigned N_COLS  = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned SCALE_W = 16,
  parameter int unsigned OUT_W   = 8
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_capture,
  input  logic [N_COLS*ACC_W-1:0]   i_acc,
  input  logic [SCALE_W-1:0]        i_scale,
  input  logic [5:0]                i_shift,
  input  logic [OUT_W-1:0]          i_zero_point,
  output logic                      o_busy,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [OUT_W-1:0]          o_data,
  output logic [$clog2(N_COLS)-1:0] o_index,
  output logic                      o_last
);

  localparam int unsigned IDX_W  = $clog2(N_COLS);
  localparam int unsigned PROD_W = ACC_W + SCALE_W;
  // One extra bit so the rounding bias cannot overflow the largest product.
  localparam int unsigned RND_W  = PROD_W + 1;

  typedef enum logic [1:0] {StIdle, StDrain, StFlush} state_e;

  state_e                   state_q, state_d;
  logic [N_COLS*ACC_W-1:0]  row_q;
  logic [SCALE_W-1:0]       scale_q;
  logic [5:0]               shift_q;
  logic [OUT_W-1:0]         zp_q;
  logic [IDX_W-1:0]         issue_q;

  logic                     s1_valid_q;
  logic signed [PROD_W-1:0] s1_prod_q;
  logic [IDX_W-1:0]         s1_idx_q;
  logic                     s2_valid_q;
  logic signed [RND_W-1:0]  s2_val_q;
  logic [IDX_W-1:0]         s2_idx_q;

  logic                     advance;
  logic                     capture_fire;
  logic                     issue_fire;
  logic                     issue_last;
  logic                     last_hs;
  logic signed [ACC_W-1:0]  acc_sel;
  logic signed [PROD_W-1:0] prod;
  logic [5:0]               sh_c;
  logic signed [RND_W-1:0]  p_ext;
  logic signed [RND_W-1:0]  bias;
  logic signed [RND_W-1:0]  rounded;
  logic signed [RND_W-1:0]  zp_sum;
  logic [OUT_W-1:0]         sat_val;

  // A presented beat that is not accepted freezes the whole pipeline.
  assign advance      = !(o_valid && !i_ready);
  assign capture_fire = (state_q == StIdle) && i_capture;
  assign issue_fire   = (state_q == StDrain) && advance;
  assign issue_last   = (issue_q == IDX_W'(N_COLS - 1));
  assign last_hs      = o_valid && i_ready && o_last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_capture) state_d = StDrain;
      StDrain: if (issue_fire && issue_last) state_d = StFlush;
      StFlush: if (last_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // S1 operand select and product.
  assign acc_sel = $signed(row_q[issue_q*ACC_W +: ACC_W]);
  assign prod    = acc_sel * $signed(scale_q);

  // S2 round half toward +inf, then arithmetic shift; shift 0 adds no bias.
  always_comb begin
    sh_c    = (shift_q > 6'(PROD_W - 1)) ? 6'(PROD_W - 1) : shift_q;
    p_ext   = {s1_prod_q[PROD_W-1], s1_prod_q};
    bias    = '0;
    if (sh_c != 6'd0) bias = RND_W'(1) << (sh_c - 6'd1);
    rounded = (p_ext + bias) >>> sh_c;
  end

  // S3 zero-point add and saturation.
  always_comb begin
    zp_sum  = s2_val_q + RND_W'($signed(zp_q));
    sat_val = zp_sum[OUT_W-1:0];
    if (zp_sum > $signed({{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}})) begin
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (zp_sum < $signed({{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}})) begin
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= StIdle;
      o_busy  <= 1'b0;
      row_q   <= '0;
      scale_q <= '0;
      shift_q <= '0;
      zp_q    <= '0;
      issue_q <= '0;
    end else begin
      state_q <= state_d;
      o_busy  <= (state_d != StIdle);
      if (capture_fire) begin
        row_q   <= i_acc;
        scale_q <= i_scale;
        shift_q <= i_shift;
        zp_q    <= i_zero_point;
        issue_q <= '0;
      end else if (issue_fire && !issue_last) begin
        issue_q <= issue_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_val_q   <= '0;
      s2_idx_q   <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_index    <= '0;
      o_last     <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= issue_fire;
      s1_prod_q  <= prod;
      s1_idx_q   <= issue_q;
      s2_valid_q <= s1_valid_q;
      s2_val_q   <= rounded;
      s2_idx_q   <= s1_idx_q;
      o_valid    <= s2_valid_q;
      o_data     <= sat_val;
      o_index    <= s2_idx_q;
      o_last     <= s2_valid_q && (s2_idx_q == IDX_W'(N_COLS - 1));
    end
  end

endmodule

// File: tb/tb_pe_row_requant.sv
module tb_pe_row_requant;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int SW = 16;
  localparam int OW = 8;
  localparam int IW = 3;

  logic              i_clk;
  logic              i_arst;
  logic              i_capture;
  logic [N*AW-1:0]   i_acc;
  logic [SW-1:0]     i_scale;
  logic [5:0]        i_shift;
  logic [OW-1:0]     i_zero_point;
  logic              o_busy;
  logic              o_valid;
  logic              i_ready;
  logic [OW-1:0]     o_data;
  logic [IW-1:0]     o_index;
  logic              o_last;

  pe_row_requant #(
    .N_COLS (N),
    .ACC_W  (AW),
    .SCALE_W(SW),
    .OUT_W  (OW)
  ) u_dut (
    .i_clk       (i_clk),
    .i_arst      (i_arst),
    .i_capture   (i_capture),
    .i_acc       (i_acc),
    .i_scale     (i_scale),
    .i_shift     (i_shift),
    .i_zero_point(i_zero_point),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_index     (o_index),
    .o_last      (o_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int data;
    int idx;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    row[N];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, floor shift on 64-bit values.
  function automatic int model(input int acc, input int scale, input int sh, input int zp);
    longint p;
    int     s;
    p = longint'(acc) * longint'(scale);
    s = (sh > 47) ? 47 : sh;
    if (s > 0) p = (p + (longint'(1) << (s - 1))) >>> s;
    p = p + zp;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return int'(p);
  endfunction

  // Scoreboard monitor: beats and stall stability checked on the falling edge.
  bit stall_seen = 0;
  int held_data;
  int held_idx;
  always @(negedge i_clk) begin
    beat_t b;
    if (i_arst) begin
      stall_seen = 0;
    end else begin
      if (stall_seen) begin
        check_eq("stall_valid", longint'(o_valid), 1);
        check_eq("stall_data", $signed(o_data), held_data);
        check_eq("stall_index", o_index, held_idx);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check_eq("beat_data", $signed(o_data), b.data);
          check_eq("beat_index", o_index, b.idx);
          check_eq("beat_last", longint'(o_last), longint'(b.last));
        end
      end
      stall_seen = o_valid && !i_ready;
      held_data  = $signed(o_data);
      held_idx   = int'(o_index);
    end
  end

  // Drives row[] with the given config for one cycle, then scrambles the inputs.
  task automatic capture(input int scale, input int sh, input int zp, input bit accept);
    beat_t b;
    i_capture = 1'b1;
    for (int k = 0; k < N; k++) i_acc[k*AW +: AW] = row[k];
    i_scale      = scale[SW-1:0];
    i_shift      = sh[5:0];
    i_zero_point = zp[OW-1:0];
    if (accept) begin
      for (int k = 0; k < N; k++) begin
        b.data = model(row[k], scale, sh, zp);
        b.idx  = k;
        b.last = (k == N - 1);
        exp_q.push_back(b);
      end
    end
    @(posedge i_clk);
    #1;
    i_capture = 1'b0;
    for (int k = 0; k < N; k++) i_acc[k*AW +: AW] = $urandom;
    i_scale      = SW'($urandom);
    i_shift      = 6'($urandom);
    i_zero_point = OW'($urandom);
  endtask

  // Returns just after the edge that accepts the final expected beat.
  task automatic wait_empty();
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      @(posedge i_clk);
      #1;
    end
    check_eq("drain_done", exp_q.size(), 0);
    check_eq("busy_fall", longint'(o_busy), 0);
  endtask

  // Returns just after the edge that accepts beat idx.
  task automatic wait_beat(input int idx);
    bit found;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge i_clk);
      if (o_valid && i_ready && (int'(o_index) == idx)) found = 1;
    end
    check_eq("beat_seen", longint'(found), 1);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_arst       = 1'b1;
    i_capture    = 1'b0;
    i_acc        = '0;
    i_scale      = '0;
    i_shift      = '0;
    i_zero_point = '0;
    i_ready      = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_valid", longint'(o_valid), 0);
    check_eq("rst_busy", longint'(o_busy), 0);
    check_eq("rst_data", longint'(o_data), 0);
    check_eq("rst_last", longint'(o_last), 0);
    i_arst = 1'b0;
    @(posedge i_clk);
    #1;

    // Rounding and latency.
    row = '{1000, -1000, 12, -12, 4, -4, 7, -7};
    capture(1, 3, 0, 1);
    check_eq("busy_rise", longint'(o_busy), 1);
    check_eq("lat_t0", longint'(o_valid), 0);
    @(posedge i_clk); #1;
    check_eq("lat_t1", longint'(o_valid), 0);
    @(posedge i_clk); #1;
    check_eq("lat_t2", longint'(o_valid), 0);
    @(posedge i_clk); #1;
    check_eq("lat_t3", longint'(o_valid), 1);
    check_eq("lat_index", o_index, 0);
    wait_empty();

    // Saturation, zero point and scale path.
    row = '{100000, -100000, 127, 128, -128, -129, 0, 1};
    capture(1, 0, 0, 1);
    wait_empty();
    row = '{20, 125, -200, 0, 3, -3, 100, -100};
    capture(1, 0, -5, 1);
    wait_empty();
    row = '{125, 118, 117, -138, -139, 0, 1, -1};
    capture(1, 0, 10, 1);
    wait_empty();
    row = '{40, -40, 41, -41, 1, -1, 0, 2};
    capture(-3, 1, 0, 1);
    wait_empty();
    row = '{32'h7fffffff, 32'h80000000, -5, 5, 1 << 30, -(1 << 30), 99, -99};
    capture(-32768, 63, 3, 1);
    wait_empty();

    // Backpressure: 5-cycle stall after beat 2, 1-cycle stall on the last beat.
    row = '{10, 20, 30, 40, 50, 60, 70, 80};
    capture(3, 2, -7, 1);
    wait_beat(2);
    i_ready = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    wait_beat(6);
    i_ready = 1'b0;
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    wait_empty();

    // Capture while busy is ignored; capture on the first idle cycle is taken,
    // giving back-to-back rows with the second row's config.
    row = '{1, 2, 3, 4, 5, 6, 7, 8};
    capture(100, 2, 0, 1);
    row = '{-9, -9, -9, -9, -9, -9, -9, -9};
    capture(7, 0, 1, 0);
    wait_empty();
    row = '{-500, 500, 250, -250, 17, -17, 9, -9};
    capture(5, 4, 3, 1);
    check_eq("b2b_busy", longint'(o_busy), 1);
    wait_empty();

    // Reset mid-drain aborts the row.
    row = '{11, 22, 33, 44, 55, 66, 77, 88};
    capture(1, 0, 0, 1);
    wait_beat(3);
    i_arst = 1'b1;
    #1;
    check_eq("arst_valid", longint'(o_valid), 0);
    check_eq("arst_busy", longint'(o_busy), 0);
    check_eq("arst_data", longint'(o_data), 0);
    check_eq("arst_index", o_index, 0);
    check_eq("arst_last", longint'(o_last), 0);
    exp_q.delete();
    @(posedge i_clk);
    #1;
    i_arst = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    check_eq("post_rst_idle", longint'(o_valid), 0);
    row = '{-1, -2, -3, -4, -5, -6, -7, -8};
    capture(-2, 1, 4, 1);
    wait_empty();

    // Random rows with random backpressure.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) row[k] = int'($urandom);
      capture(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 63)),
              int'($urandom_range(0, 255)) - 128, 1);
      for (int c = 0; c < 20; c++) begin
        i_ready = 1'($urandom_range(0, 1));
        @(posedge i_clk);
        #1;
      end
      i_ready = 1'b1;
      wait_empty();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
